// File: rtl/adder_pkg.sv
// Shared definitions for the add/sub pipeline.
//   MODE_ADD / MODE_SUB : encodings of the per-beat mode input.
//   sat_max / sat_min   : most positive / most negative two's-complement value of a
//                         given width, returned sign-extended to 64 bits so callers
//                         can take the low bits they need.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // 2^(width-1) - 1
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // -2^(width-1); the bitwise complement of sat_max is exactly that, sign-extended.
  function automatic logic [63:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

endpackage

// File: rtl/add_sub_lane.sv
// One combinational add/subtract lane with signed overflow detect.
// Optional saturation is enabled by defining ADD_SUB_PIPE_SAT_EN; otherwise the
// result wraps modulo 2^BIT. The ovf flag is identical in both builds.
// Ports:
//   a, b  : BIT-bit two's-complement operands
//   mode  : MODE_ADD (a+b) or MODE_SUB (a-b)
//   c     : BIT-bit result (wrapped or saturated)
//   ovf   : exact result did not fit in BIT bits
module add_sub_lane
  import adder_pkg::*;
#(
  parameter int unsigned BIT = 40
) (
  input  logic [BIT-1:0] a,
  input  logic [BIT-1:0] b,
  input  logic           mode,
  output logic [BIT-1:0] c,
  output logic           ovf
);

  logic [BIT:0] a_ext;
  logic [BIT:0] b_ext;
  logic [BIT:0] sum;

  // One guard bit makes every BIT-bit add/sub exact, including a - (-2^(BIT-1)).
  assign a_ext = {a[BIT-1], a};
  assign b_ext = {b[BIT-1], b};
  assign sum   = (mode == MODE_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);

  // The exact result fits iff the guard bit equals the result sign bit.
  assign ovf = sum[BIT] ^ sum[BIT-1];

`ifdef ADD_SUB_PIPE_SAT_EN
  localparam logic [63:0] MaxFull = sat_max(BIT);
  localparam logic [63:0] MinFull = sat_min(BIT);

  // Guard bit carries the true sign of the exact result.
  always_comb begin
    c = sum[BIT-1:0];
    if (ovf) begin
      c = sum[BIT] ? MinFull[BIT-1:0] : MaxFull[BIT-1:0];
    end
  end
`else
  assign c = sum[BIT-1:0];
`endif

endmodule

// File: rtl/add_sub_pipe.sv
// Multi-lane pipelined signed adder/subtractor with valid/ready handshake.
// Arithmetic is registered into stage 0; stages 1..STAGES-1 only delay the data.
// Each stage advances when valid and the next stage is empty or advancing, so the
// pipe runs at one beat per cycle and stalls cleanly under backpressure.
// Optional macro: ADD_SUB_PIPE_SAT_EN (saturate on overflow instead of wrapping).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake
//   mode                : 0 add, 1 subtract, for all lanes of the beat
//   A_in, B_in          : LANES packed BIT-bit operands, lane i at [i*BIT +: BIT]
//   out_valid/out_ready : output handshake
//   C_out               : packed per-lane results
//   ovf                 : per-lane signed overflow flags
module add_sub_pipe
  import adder_pkg::*;
#(
  parameter int unsigned BIT    = 40,
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [LANES*BIT-1:0] A_in,
  input  logic [LANES*BIT-1:0] B_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*BIT-1:0] C_out,
  output logic [LANES-1:0]     ovf
);

  logic [LANES*BIT-1:0] lane_c;
  logic [LANES-1:0]     lane_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    add_sub_lane #(
      .BIT (BIT)
    ) u_lane (
      .a    (A_in[i*BIT +: BIT]),
      .b    (B_in[i*BIT +: BIT]),
      .mode (mode),
      .c    (lane_c[i*BIT +: BIT]),
      .ovf  (lane_ovf[i])
    );
  end

  logic [STAGES-1:0]    valid_q;
  logic [STAGES-1:0]    valid_d;
  logic [STAGES-1:0]    adv;
  logic [STAGES-1:0]    load;
  logic [LANES*BIT-1:0] data_q [STAGES];
  logic [LANES-1:0]     ovf_q  [STAGES];
  logic [LANES*BIT-1:0] data_in [STAGES];
  logic [LANES-1:0]     ovf_in  [STAGES];
  logic                 in_fire;

  // Advance chain runs from the output back to stage 0; it depends only on state
  // and out_ready, so in_ready never sees in_valid.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STAGES - 1) begin : g_last
      assign adv[k] = valid_q[k] & out_ready;
    end else begin : g_mid
      assign adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
    end

    if (k == 0) begin : g_first
      assign load[k]    = in_fire;
      assign data_in[k] = lane_c;
      assign ovf_in[k]  = lane_ovf;
    end else begin : g_next
      assign load[k]    = adv[k-1];
      assign data_in[k] = data_q[k-1];
      assign ovf_in[k]  = ovf_q[k-1];
    end
  end

  assign in_ready = ~valid_q[0] | adv[0];
  assign in_fire  = in_valid & in_ready;

  // A stage that both empties and refills stays valid.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = 1'b0;
      end
      if (load[k]) begin
        valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        ovf_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          data_q[k] <= data_in[k];
          ovf_q[k]  <= ovf_in[k];
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign C_out     = data_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe with BIT=8, LANES=2, STAGES=2.
// Expected beats are pushed when the input handshake completes and popped when the
// output handshake completes. Honours ADD_SUB_PIPE_SAT_EN for expected values.
module tb_add_sub_pipe;
  import adder_pkg::*;

  localparam int unsigned BIT    = 8;
  localparam int unsigned LANES  = 2;
  localparam int unsigned STAGES = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [15:0] A_in;
  logic [15:0] B_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] C_out;
  logic [1:0]  ovf;

  add_sub_pipe #(
    .BIT    (BIT),
    .LANES  (LANES),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .A_in      (A_in),
    .B_in      (B_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C_out     (C_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;

  logic [17:0] sb_q [$];  // {ovf, C_out}

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference for one lane: exact integer arithmetic, then wrap or saturate.
  function automatic logic [8:0] model_lane(input logic [7:0] a, input logic [7:0] b,
                                            input logic m);
    int ea;
    int eb;
    int ex;
    logic       ov;
    logic [7:0] r;
    ea = int'($signed(a));
    eb = int'($signed(b));
    ex = (m == MODE_SUB) ? (ea - eb) : (ea + eb);
    ov = (ex > 127) || (ex < -128);
    r  = ex[7:0];
`ifdef ADD_SUB_PIPE_SAT_EN
    if (ov) r = (ex > 0) ? 8'h7f : 8'h80;
`endif
    return {ov, r};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1,
                      input logic [7:0] b1, input logic m, input logic [15:0] ec,
                      input logic [1:0] eo, output int waits);
    bit done;
    done     = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    mode     = m;
    A_in     = {a1, a0};
    B_in     = {b1, b0};
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back({eo, ec});
        accepted++;
        done = 1'b1;
      end else if (waits > 100) begin
        check_eq("accept_timeout", 64'(in_ready), 64'd1);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int waits);
    logic [7:0] a0, b0, a1, b1;
    logic       m;
    logic [8:0] r0, r1;
    a0 = 8'($urandom_range(0, 255));
    b0 = 8'($urandom_range(0, 255));
    a1 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    m  = 1'($urandom_range(0, 1));
    r0 = model_lane(a0, b0, m);
    r1 = model_lane(a1, b1, m);
    send(a0, b0, a1, b1, m, {r1[7:0], r0[7:0]}, {r1[8], r0[8]}, waits);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", 64'(sb_q.size()), 64'd0);
  endtask

  // Output monitor: compares transferring beats and checks hold while stalled.
  logic        held;
  logic [15:0] held_c;
  logic [1:0]  held_o;
  logic [17:0] exp_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_c", 64'(C_out), 64'(held_c));
        check_eq("hold_ovf", 64'(ovf), 64'(held_o));
      end
      if (out_valid && !out_ready) begin
        held   = 1'b1;
        held_c = C_out;
        held_o = ovf;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_beat", 64'(out_valid), 64'd0);
        end else begin
          exp_beat = sb_q.pop_front();
          check_eq("c_out", 64'(C_out), 64'(exp_beat[15:0]));
          check_eq("ovf", 64'(ovf), 64'(exp_beat[17:16]));
        end
      end
    end
  end

  int w;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode      = MODE_ADD;
    A_in      = '0;
    B_in      = '0;
    out_ready = 1'b1;

    #3;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_c_out", 64'(C_out), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Add: lane0 5 + -3 = 2, lane1 10 + 20 = 30; check two-cycle latency.
    send(8'd5, 8'hfd, 8'd10, 8'd20, MODE_ADD, {8'd30, 8'd2}, 2'b00, w);
    check_eq("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_eq("lat_valid", 64'(out_valid), 64'd1);
    check_eq("lat_c_lane0", 64'(C_out[7:0]), 64'd2);
    drain();

    // Overflow: lane0 127 - (-1), lane1 -128 - 1.
`ifdef ADD_SUB_PIPE_SAT_EN
    send(8'h7f, 8'hff, 8'h80, 8'h01, MODE_SUB, {8'h80, 8'h7f}, 2'b11, w);
`else
    send(8'h7f, 8'hff, 8'h80, 8'h01, MODE_SUB, {8'h7f, 8'h80}, 2'b11, w);
`endif
    // Edge: lane0 0 - (-128), lane1 3 - 4 = -1.
`ifdef ADD_SUB_PIPE_SAT_EN
    send(8'h00, 8'h80, 8'h03, 8'h04, MODE_SUB, {8'hff, 8'h7f}, 2'b01, w);
`else
    send(8'h00, 8'h80, 8'h03, 8'h04, MODE_SUB, {8'hff, 8'h80}, 2'b01, w);
`endif
    drain();

    // Streaming at full rate: no wait states expected.
    for (int i = 0; i < 10; i++) begin
      send_rand(w);
      check_eq("tput_wait", 64'(w), 64'd0);
    end
    drain();

    // Backpressure: 6 beats while out_ready is low for 4 cycles.
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_rand(w);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_accepted", 64'(accepted), 64'd2);
        out_ready = 1'b1;
        #1;
        check_eq("bp_no_bubble", 64'(in_ready), 64'd1);
      end
    join
    drain();

    // Reset with two beats in flight: they must vanish.
    out_ready = 1'b0;
    send_rand(w);
    send_rand(w);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst2_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst2_c_out", 64'(C_out), 64'd0);
    check_eq("rst2_ovf", 64'(ovf), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst2_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send_rand(w);
    drain();
    // Any stale beat surfacing now is flagged by the monitor.
    repeat (6) @(posedge clk);
    #1;
    check_eq("idle_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
